// File: rtl/tt_edge_streamer.sv
// Front-end feeder for the track-travel shortest-path engine: collects row masks into
// a 16-node undirected edge set, then streams the query pair and every edge once.
module tt_edge_streamer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    input  logic [3:0]  cfg_row,
    input  logic [15:0] cfg_mask,
    input  logic        cfg_last,
    input  logic [3:0]  qry_src,
    input  logic [3:0]  qry_dst,
    input  logic        tt_done,
    output logic        cfg_ready,
    output logic        out_valid,
    output logic [3:0]  source,
    output logic [3:0]  destination
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        QUERY,
        EMIT,
        WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] adj_q [16];
    logic [15:0] adj_d [16];
    logic [15:0] adjClr [16];
    logic [3:0]  qsrc_q, qsrc_d;
    logic [3:0]  qdst_q, qdst_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  src_q, src_d;
    logic [3:0]  dst_q, dst_d;

    logic        found;
    logic        moreLeft;
    logic [3:0]  selI;
    logic [3:0]  selJ;
    logic        accept;

    assign cfg_ready   = (state_q == IDLE) || (state_q == LOAD);
    assign accept      = cfg_valid && cfg_ready;
    assign out_valid   = out_valid_q;
    assign source      = src_q;
    assign destination = dst_q;

    // Row i only ever holds bits j > i; scanning downward lets the lowest entry win.
    always_comb begin
        found = 1'b0;
        selI  = 4'd0;
        selJ  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            for (int j = 15; j > i; j--) begin
                if (adj_q[i][j]) begin
                    found = 1'b1;
                    selI  = 4'(i);
                    selJ  = 4'(j);
                end
            end
        end
    end

    always_comb begin
        adjClr = adj_q;
        adjClr[selI][selJ] = 1'b0;
        moreLeft = 1'b0;
        for (int r = 0; r < 16; r++) begin
            moreLeft = moreLeft | (|adjClr[r]);
        end
    end

    always_comb begin
        state_d     = state_q;
        adj_d       = adj_q;
        qsrc_d      = qsrc_q;
        qdst_d      = qdst_q;
        out_valid_d = 1'b0;
        src_d       = 4'd0;
        dst_d       = 4'd0;

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    // Fold each edge into the (min, max) slot so mirrors collapse.
                    for (int j = 0; j < 16; j++) begin
                        if (cfg_mask[j] && (4'(j) != cfg_row)) begin
                            if (4'(j) > cfg_row) begin
                                adj_d[cfg_row][j] = 1'b1;
                            end else begin
                                adj_d[j][cfg_row] = 1'b1;
                            end
                        end
                    end
                    if (cfg_last) begin
                        qsrc_d  = qry_src;
                        qdst_d  = qry_dst;
                        state_d = QUERY;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            QUERY: begin
                out_valid_d = 1'b1;
                src_d       = qsrc_q;
                dst_d       = qdst_q;
                state_d     = found ? EMIT : WAIT;
            end
            EMIT: begin
                out_valid_d = 1'b1;
                src_d       = selI;
                dst_d       = selJ;
                adj_d       = adjClr;
                if (!moreLeft) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tt_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            qsrc_q      <= 4'd0;
            qdst_q      <= 4'd0;
            out_valid_q <= 1'b0;
            src_q       <= 4'd0;
            dst_q       <= 4'd0;
            for (int r = 0; r < 16; r++) begin
                adj_q[r] <= 16'd0;
            end
        end else begin
            state_q     <= state_d;
            qsrc_q      <= qsrc_d;
            qdst_q      <= qdst_d;
            out_valid_q <= out_valid_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            for (int r = 0; r < 16; r++) begin
                adj_q[r] <= adj_d[r];
            end
        end
    end

endmodule

// File: tb/tb_tt_edge_streamer.sv
// Scoreboard bench for tt_edge_streamer: a reference edge-set model queues the expected
// stream per frame and the output is checked cycle by cycle for latency and gaps.
module tb_tt_edge_streamer;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic [3:0]  cfg_row;
    logic [15:0] cfg_mask;
    logic        cfg_last;
    logic [3:0]  qry_src;
    logic [3:0]  qry_dst;
    logic        tt_done;
    logic        cfg_ready;
    logic        out_valid;
    logic [3:0]  source;
    logic [3:0]  destination;

    typedef struct {
        logic [3:0] s;
        logic [3:0] d;
    } pair_t;

    pair_t       expQ [$];
    logic [15:0] mAdj [16];
    int          checks = 0;
    int          failures = 0;

    tt_edge_streamer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_row     (cfg_row),
        .cfg_mask    (cfg_mask),
        .cfg_last    (cfg_last),
        .qry_src     (qry_src),
        .qry_dst     (qry_dst),
        .tt_done     (tt_done),
        .cfg_ready   (cfg_ready),
        .out_valid   (out_valid),
        .source      (source),
        .destination (destination)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one beat from a negedge; the reference set is updated as the beat is accepted.
    task automatic applyStimulus(input logic [3:0] row, input logic [15:0] mask,
                                 input logic last, input logic [3:0] qs, input logic [3:0] qd);
        cfg_valid = 1'b1;
        cfg_row   = row;
        cfg_mask  = mask;
        cfg_last  = last;
        qry_src   = qs;
        qry_dst   = qd;
        checkOutput("cfgReadyBeat", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (mask[j] && (j != int'(row))) begin
                if (j > int'(row)) mAdj[row][j] = 1'b1;
                else mAdj[j][row] = 1'b1;
            end
        end
        if (last) begin
            expQ.push_back('{s: qs, d: qd});
            for (int i = 0; i < 16; i++) begin
                for (int j = i + 1; j < 16; j++) begin
                    if (mAdj[i][j]) expQ.push_back('{s: 4'(i), d: 4'(j)});
                end
            end
            for (int i = 0; i < 16; i++) mAdj[i] = 16'd0;
        end
    endtask

    // Called on the negedge right after the cfg_last beat; optionally pulses junk mid-stream.
    task automatic drainStream(input int pulseAt);
        int    n;
        pair_t p;
        n = expQ.size();
        checkOutput("queryLatency", int'(out_valid), 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            p = expQ.pop_front();
            checkOutput("streamValid", int'(out_valid), 1);
            checkOutput("streamSrc", int'(source), int'(p.s));
            checkOutput("streamDst", int'(destination), int'(p.d));
            if (k == pulseAt) begin
                cfg_valid = 1'b1;
                cfg_row   = 4'd12;
                cfg_mask  = 16'hFFFF;
                cfg_last  = 1'b1;
                tt_done   = 1'b1;
            end else begin
                cfg_valid = 1'b0;
                cfg_last  = 1'b0;
                tt_done   = 1'b0;
            end
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        tt_done   = 1'b0;
        checkOutput("streamEndValid", int'(out_valid), 0);
        checkOutput("streamEndSrc", int'(source), 0);
        checkOutput("streamEndDst", int'(destination), 0);
        checkOutput("waitNotReady", int'(cfg_ready), 0);
        @(negedge clk);
        checkOutput("waitHoldValid", int'(out_valid), 0);
        checkOutput("waitHoldReady", int'(cfg_ready), 0);
    endtask

    task automatic finishFrame();
        tt_done = 1'b1;
        @(negedge clk);
        tt_done = 1'b0;
        checkOutput("doneToIdle", int'(cfg_ready), 1);
    endtask

    initial begin
        pair_t p;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_row   = 4'd0;
        cfg_mask  = 16'd0;
        cfg_last  = 1'b0;
        qry_src   = 4'd0;
        qry_dst   = 4'd0;
        tt_done   = 1'b0;
        for (int i = 0; i < 16; i++) mAdj[i] = 16'd0;

        repeat (2) @(negedge clk);
        checkOutput("resetValid", int'(out_valid), 0);
        checkOutput("resetSrc", int'(source), 0);
        checkOutput("resetDst", int'(destination), 0);
        checkOutput("resetReady", int'(cfg_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] frame 1: triangle 0-1-2");
        applyStimulus(4'd0, 16'h0006, 1'b0, 4'd0, 4'd2);
        applyStimulus(4'd1, 16'h0004, 1'b1, 4'd0, 4'd2);
        checkOutput("frame1Len", expQ.size(), 4);
        drainStream(-1);
        finishFrame();

        $display("[TB] frame 2: mirrored duplicate edge");
        applyStimulus(4'd5, 16'h0008, 1'b0, 4'd3, 4'd5);
        applyStimulus(4'd3, 16'h0020, 1'b1, 4'd3, 4'd5);
        checkOutput("frame2Len", expQ.size(), 2);
        drainStream(-1);
        finishFrame();

        $display("[TB] frame 3: self loop only");
        applyStimulus(4'd7, 16'h0080, 1'b1, 4'd7, 4'd9);
        checkOutput("frame3Len", expQ.size(), 1);
        drainStream(-1);
        finishFrame();

        $display("[TB] frame 4: complete graph");
        for (int r = 0; r < 16; r++) begin
            applyStimulus(4'(r), 16'hFFFF, (r == 15), 4'd0, 4'd15);
        end
        checkOutput("fullLen", expQ.size(), 121);
        checkOutput("fullSecondSrc", int'(expQ[1].s), 0);
        checkOutput("fullSecondDst", int'(expQ[1].d), 1);
        checkOutput("fullLastDst", int'(expQ[120].d), 15);
        drainStream(-1);
        finishFrame();

        $display("[TB] frame 5: junk cfg_valid and tt_done during EMIT");
        applyStimulus(4'd0, 16'h0006, 1'b0, 4'd0, 4'd2);
        applyStimulus(4'd1, 16'h0004, 1'b1, 4'd0, 4'd2);
        drainStream(1);
        finishFrame();

        $display("[TB] frame 6: clean second frame after the junk");
        applyStimulus(4'd2, 16'h0010, 1'b1, 4'd2, 4'd4);
        checkOutput("frame6Len", expQ.size(), 2);
        drainStream(-1);
        finishFrame();

        $display("[TB] frame 7: reset mid-stream then reload");
        applyStimulus(4'd0, 16'h0006, 1'b0, 4'd0, 4'd2);
        applyStimulus(4'd1, 16'h0004, 1'b1, 4'd0, 4'd2);
        checkOutput("preRstLatency", int'(out_valid), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            p = expQ.pop_front();
            checkOutput("preRstValid", int'(out_valid), 1);
            checkOutput("preRstSrc", int'(source), int'(p.s));
            checkOutput("preRstDst", int'(destination), int'(p.d));
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", int'(out_valid), 0);
        checkOutput("midRstSrc", int'(source), 0);
        checkOutput("midRstDst", int'(destination), 0);
        checkOutput("midRstReady", int'(cfg_ready), 1);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'd0, 16'h0006, 1'b0, 4'd0, 4'd2);
        applyStimulus(4'd1, 16'h0004, 1'b1, 4'd0, 4'd2);
        checkOutput("reloadLen", expQ.size(), 4);
        drainStream(-1);
        finishFrame();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_edge_streamer.md
# tt_edge_streamer

Upstream feeder for the track-travel shortest-path engine. Accepts a graph as per-node adjacency row masks plus one source/destination query, stores it as a 16-node undirected adjacency set, and replays it as the contiguous `in_valid`/`source`/`destination` stream the engine consumes: query pair first, then every distinct edge once. It then holds off the next frame until the engine reports its result.

## Interface
- No parameters. Node count is fixed at 16 and node IDs are 4 bits.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: row-mask beat valid.
- `cfg_row` in 4: node index of the row.
- `cfg_mask` in 16: bit j set means edge (cfg_row, j).
- `cfg_last` in 1: final beat of the frame; qualified by `cfg_valid`.
- `qry_src` in 4: query source; sampled on the accepted `cfg_last` beat.
- `qry_dst` in 4: query destination; sampled on the accepted `cfg_last` beat.
- `tt_done` in 1: engine result strobe (its `out_valid`).
- `cfg_ready` out 1: high in IDLE and LOAD; beats are accepted only when `cfg_valid && cfg_ready`.
- `out_valid` out 1: stream valid. Registered. Drives engine `in_valid`.
- `source` out 4: stream source. Registered.
- `destination` out 4: stream destination. Registered.

## Operation
- Storage is an upper-triangular adjacency set of 120 bits, entry (i, j) with i < j.
- On an accepted beat, for each j != cfg_row with cfg_mask[j] = 1, set entry (min(cfg_row, j), max(cfg_row, j)).
  - Bit cfg_row (self loop) is ignored.
  - Beats OR into storage, so repeated rows and mirrored edges collapse to one entry.
- States and transitions:
  - IDLE: storage is all-zero; cfg_ready = 1. An accepted beat moves to LOAD, or straight to QUERY if cfg_last = 1.
  - LOAD: cfg_ready = 1. An accepted beat with cfg_last = 1 moves to QUERY.
  - QUERY: out_valid = 1, source = captured qry_src, destination = captured qry_dst. Moves to EMIT if any entry is set, else to WAIT.
  - EMIT: each cycle, output the lowest remaining entry in row-major order (i ascending, then j ascending) as (source = i, destination = j) and clear that entry. The cycle that emits the last set entry moves to WAIT.
  - WAIT: out_valid = 0. tt_done = 1 moves to IDLE.
- The stream is gap-free: out_valid is high for exactly 1 + E consecutive cycles, where E is the number of distinct edges (0..120). The engine ends its read on the first low cycle, so a gap is a functional bug.
- qry_src == qry_dst is passed through unchanged.
- tt_done is ignored in every state other than WAIT.
- cfg_valid is ignored when cfg_ready = 0.
- When out_valid = 0, source and destination are driven to 0.

## Timing
- Reset values:
  - state = IDLE
  - storage = 0
  - out_valid = 0, source = 0, destination = 0
  - cfg_ready = 1 (combinational from state)
- Latency: accepted cfg_last beat at edge T gives the query pair on the outputs in cycle T+1 (after edge T+1 registers it). Edges follow in cycles T+2 .. T+1+E.
- Edge selection is a single-cycle priority encoder over the 120 entries. There are no bubbles on empty rows.
- Stream end: out_valid falls in the cycle after the last edge; the state is WAIT from then on.
- tt_done sampled high in WAIT gives IDLE and cfg_ready = 1 in the next cycle.
- Reset asserted mid-frame clears everything immediately (asynchronous). The first beat after reset release starts a clean frame.
- Worst-case frame: 16 beats, then 121 stream cycles.

## Test plan
- Row 0 mask 0x0006, then row 1 mask 0x0004 with cfg_last, qry 0->2 -> out_valid high for 4 consecutive cycles: (0,2), (0,1), (0,2), (1,2); then low, WAIT.
- Row 5 mask 0x0008, then row 3 mask 0x0020 with cfg_last, qry 3->5 -> stream (3,5), (3,5) only; the duplicate edge is collapsed.
- Single beat: row 7 mask 0x0080 with cfg_last, qry 7->9 -> one cycle (7,9), then WAIT; the self loop is dropped.
- Rows 0..15 all mask 0xFFFF, qry 0->15 -> 121 contiguous valid cycles; the second is (0,1) and the last is (14,15).
- cfg_valid pulsed during EMIT and tt_done pulsed during EMIT -> both ignored, stream unchanged. tt_done in WAIT -> cfg_ready = 1 next cycle, and a second frame streams correctly starting from empty storage.
- rst_n pulsed low mid-EMIT -> outputs 0 immediately, state IDLE. Reloading the scenario 1 frame reproduces the scenario 1 stream.
